// File: rtl/memtest_gen.sv
`default_nettype none
// ==========================================================================
// memtest_gen : FML burst memory tester (write/read bursts, data check, irq)
// Option MEMTEST_GEN_FIRSTERR_EN builds first-error address capture. Rev 1.0
// ==========================================================================
module memtest_gen #(
  parameter logic [4:0] csr_addr  = 5'h0,
  parameter int         fml_depth = 26,
  parameter int         fml_dw    = 64,
  parameter int         burst_len = 4,
  parameter int         rnd_bits  = 20
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [14:0]           csr_a,
  input  logic                  csr_we,
  input  logic [31:0]           csr_di,
  output logic [31:0]           csr_do,
  output logic [fml_depth-1:0]  fml_adr,
  output logic                  fml_stb,
  output logic                  fml_we,
  input  logic                  fml_ack,
  input  logic [fml_dw-1:0]     fml_di,
  output logic [fml_dw/8-1:0]   fml_sel,
  output logic [fml_dw-1:0]     fml_do,
  output logic                  irq
);

  localparam int BEAT_B = fml_dw / 8;
  localparam int BURST_B = BEAT_B * burst_len;
  localparam int LB = $clog2(BURST_B);

  // Fibonacci tap positions of maximal-length LFSRs, as a bit mask.
  function automatic logic [1023:0] tap_mask(input int w);
    int t [4];
    logic [1023:0] m;
    case (w)
      3:  t = '{3, 2, 0, 0};        4:  t = '{4, 3, 0, 0};
      5:  t = '{5, 3, 0, 0};        6:  t = '{6, 5, 0, 0};
      7:  t = '{7, 6, 0, 0};        8:  t = '{8, 6, 5, 4};
      9:  t = '{9, 5, 0, 0};        10: t = '{10, 7, 0, 0};
      11: t = '{11, 9, 0, 0};       12: t = '{12, 6, 4, 1};
      13: t = '{13, 4, 3, 1};       14: t = '{14, 5, 3, 1};
      15: t = '{15, 14, 0, 0};      16: t = '{16, 15, 13, 4};
      17: t = '{17, 14, 0, 0};      18: t = '{18, 11, 0, 0};
      19: t = '{19, 6, 2, 1};       20: t = '{20, 17, 0, 0};
      21: t = '{21, 19, 0, 0};      22: t = '{22, 21, 0, 0};
      23: t = '{23, 18, 0, 0};      24: t = '{24, 23, 22, 17};
      25: t = '{25, 22, 0, 0};      26: t = '{26, 6, 2, 1};
      27: t = '{27, 5, 2, 1};       28: t = '{28, 25, 0, 0};
      29: t = '{29, 27, 0, 0};      30: t = '{30, 6, 4, 1};
      31: t = '{31, 28, 0, 0};      32: t = '{32, 22, 2, 1};
      64: t = '{64, 63, 61, 60};    128: t = '{128, 126, 101, 99};
      256: t = '{256, 254, 251, 246};
      512: t = '{512, 510, 507, 504};
      1024: t = '{1024, 1015, 1002, 1001};
      default: t = '{0, 0, 0, 0};
    endcase
    m = '0;
    for (int i = 0; i < 4; i++)
      if (t[i] > 0) m[t[i]-1] = 1'b1;
    return m;
  endfunction

  localparam logic [1023:0] DMASK = tap_mask(fml_dw);
  localparam logic [1023:0] AMASK = tap_mask(rnd_bits);
  localparam logic [fml_dw-1:0] DSEED = {(fml_dw/32){32'h1f2e_3d4c}};
  localparam logic [rnd_bits-1:0] ASEED = '1;
  localparam logic [fml_depth-1:0] LOWM = {{(fml_depth-LB){1'b1}}, {LB{1'b0}}};
  localparam logic [fml_depth-1:0] RMASK =
    {{(fml_depth-rnd_bits){1'b0}}, {rnd_bits{1'b1}}} << LB;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, nxt;

  logic [31:0]          count, errcount, firsterr, rd;
  logic [fml_depth-1:0] base, seq_adr, beat_adr, rnd_adr, burst_adr, beat_adr_w;
  logic [rnd_bits-1:0]  alfsr;
  logic [fml_dw-1:0]    dlfsr, exp_beat;
  logic [2:0]           mode, cur_mode, beat_mode;
  logic [4:0]           beat_left, drain_cnt;
  logic                 done, mis;
  logic                 sel, wr, nb_wr, abort, ack, in_beat, beat, live, b_we, b_pat;
  logic [2:0]           off;
  logic                 unused;

  assign sel   = (csr_a[14:10] == csr_addr);
  assign wr    = csr_we && sel;
  assign off   = csr_a[2:0];
  assign nb_wr = wr && (off == 3'd0);
  assign abort = nb_wr && (csr_di == 32'd0);
  assign ack   = (state == RUN) && fml_ack;
  assign unused = ^{csr_a[9:3], csr_di[31:fml_depth]};

  assign rnd_adr    = (base & ~RMASK) | (fml_depth'(alfsr) << LB);
  assign burst_adr  = cur_mode[1] ? seq_adr : rnd_adr;
  assign in_beat    = (beat_left != 5'd0);
  assign beat       = ack || in_beat;
  assign live       = fml_stb || in_beat;
  // The ack cycle carries beat 0 at the burst address with the burst's mode.
  assign beat_adr_w = in_beat ? beat_adr : burst_adr;
  assign b_we       = in_beat ? beat_mode[0] : cur_mode[0];
  assign b_pat      = in_beat ? beat_mode[2] : cur_mode[2];
  assign exp_beat   = b_pat ? {(fml_dw/32){32'(beat_adr_w)}} : dlfsr;

  assign fml_stb = (state == RUN);
  assign fml_we  = fml_stb && cur_mode[0];
  assign fml_adr = fml_stb ? burst_adr : '0;
  assign fml_do  = live ? exp_beat : '0;
  assign fml_sel = {(fml_dw/8){live}};
  assign irq     = (state == DONE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (nb_wr) nxt = (csr_di != 32'd0) ? RUN : DONE;
      RUN:     if ((ack && count == 32'd1) || abort) nxt = DRAIN;
      DRAIN:   if (drain_cnt == 5'd0) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= nxt;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0; errcount <= '0; base <= '0; seq_adr <= '0; beat_adr <= '0;
      alfsr <= ASEED; dlfsr <= DSEED; mode <= '0; cur_mode <= '0; beat_mode <= '0;
      beat_left <= '0; drain_cnt <= '0; done <= 1'b0; mis <= 1'b0;
    end else begin
      if (state == IDLE && nb_wr) begin
        count    <= csr_di;
        dlfsr    <= DSEED;
        cur_mode <= mode;
      end else begin
        if (ack) begin
          count    <= count - 32'd1;
          cur_mode <= mode;
        end
        if (beat) dlfsr <= {dlfsr[fml_dw-2:0], ^(dlfsr & DMASK[fml_dw-1:0])};
      end
      if (wr && off == 3'd3) mode <= csr_di[2:0];
      if (wr && off == 3'd2) begin
        base    <= csr_di[fml_depth-1:0] & LOWM;
        seq_adr <= csr_di[fml_depth-1:0] & LOWM;
        alfsr   <= ASEED;
      end else if (ack) begin
        if (cur_mode[1]) seq_adr <= seq_adr + fml_depth'(BURST_B);
        else alfsr <= {alfsr[rnd_bits-2:0], ^(alfsr & AMASK[rnd_bits-1:0])};
      end
      if (ack) begin
        beat_left <= 5'(burst_len - 1);
        beat_adr  <= burst_adr + fml_depth'(BEAT_B);
        beat_mode <= cur_mode;
      end else if (in_beat) begin
        beat_left <= beat_left - 5'd1;
        beat_adr  <= beat_adr + fml_depth'(BEAT_B);
      end
      if (state == RUN)        drain_cnt <= 5'(burst_len - 1);
      else if (state == DRAIN) drain_cnt <= drain_cnt - 5'd1;
      mis <= beat && !b_we && (fml_di != exp_beat);
      // A clear coinciding with an error keeps that error.
      if (wr && off == 3'd1)             errcount <= {31'd0, mis};
      else if (mis && errcount != '1)    errcount <= errcount + 32'd1;
      if (wr && off == 3'd5) done <= 1'b0;
      if (state == DONE)     done <= 1'b1;
    end
  end

`ifdef MEMTEST_GEN_FIRSTERR_EN
  logic [fml_depth-1:0] mis_adr, fe_adr;
  logic                 fe_v;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mis_adr <= '0; fe_adr <= '0; fe_v <= 1'b0;
    end else begin
      mis_adr <= beat_adr_w;
      if (wr && off == 3'd1) begin
        fe_v   <= mis;
        fe_adr <= mis ? mis_adr : '0;
      end else if (mis && !fe_v) begin
        fe_v   <= 1'b1;
        fe_adr <= mis_adr;
      end
    end
  end
  assign firsterr = {fe_v, 31'(fe_adr)};
`else
  assign firsterr = 32'd0;
`endif

  always_comb begin
    rd = 32'd0;
    case (off)
      3'd0: rd = count;
      3'd1: rd = errcount;
      3'd2: rd = 32'(base);
      3'd3: rd = {29'd0, mode};
      3'd4: rd = firsterr;
      3'd5: rd = {30'd0, done, state != IDLE};
      default: rd = 32'd0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) csr_do <= '0;
    else            csr_do <= sel ? rd : 32'd0;
  end

endmodule
`default_nettype wire
